amci_arbiter: RTL
=================

Name: amci_arbiter

Overview:
- Shares one AXI4-Lite master control interface (AMCI) among NUM_REQ independent requesters, e.g. traffic generators and status pollers.
- Each requester posts a single read or write command and receives one completion pulse carrying data and response.
- Sits between the requester blocks and the axi4_lite_master instance that drives the system interconnect.
- Grants are round-robin, and only one AXI transaction is outstanding at a time.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 32, AMCI address width.
- DATA_W, 32, AMCI data width.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester command request, level; bit i = requester i.
- req_rnw  in  NUM_REQ  1 = read, 0 = write.
- req_addr  in  NUM_REQ*ADDR_W  flattened addresses; slice i = [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  flattened write data.
- done  out  NUM_REQ  one-cycle completion pulse to the owning requester.
- rsp_data  out  DATA_W  read data for the completed command (0 for writes).
- rsp_resp  out  2  AXI response of the completed command.
- busy  out  1  high from grant until done pulse.
- amci_waddr  out  ADDR_W  to master AMCI_WADDR.
- amci_wdata  out  DATA_W  to master AMCI_WDATA.
- amci_write  out  1  to master AMCI_WRITE, one-cycle pulse.
- amci_wresp  in  2  from master AMCI_WRESP.
- amci_widle  in  1  from master AMCI_WIDLE.
- amci_raddr  out  ADDR_W  to master AMCI_RADDR.
- amci_read  out  1  to master AMCI_READ, one-cycle pulse.
- amci_rdata  in  DATA_W  from master AMCI_RDATA.
- amci_rresp  in  2  from master AMCI_RRESP.
- amci_ridle  in  1  from master AMCI_RIDLE.

Behaviour:
- Reset (resetn=0, asynchronous):
  - State = IDLE; rr pointer = 0.
  - All outputs 0: done, rsp_data, rsp_resp, busy, amci_write, amci_read, amci_waddr, amci_raddr, amci_wdata.
- amci_write, amci_read and done are pulse outputs. Each defaults to 0 every cycle and is driven high for exactly one cycle.
- State machine:
  - IDLE: if any req bit is set AND both amci_widle and amci_ridle are 1, select the winner and go to ISSUE. The winner is the first set req bit searching upward from rr, wrapping modulo NUM_REQ. On selection:
    - latch the winner index, its rnw, addr and wdata;
    - busy <= 1.
  - ISSUE (1 cycle):
    - Write: amci_waddr <= addr, amci_wdata <= wdata, amci_write <= 1.
    - Read: amci_raddr <= addr, amci_read <= 1.
    - Go to SETTLE.
  - SETTLE (1 cycle): ignore the idle inputs, which the master lowers one cycle after the pulse. Go to WAIT.
  - WAIT: stay until the relevant idle (widle for writes, ridle for reads) is 1. Then:
    - capture rsp_resp (wresp/rresp);
    - capture rsp_data (rdata for reads, 0 for writes);
    - done[winner] <= 1;
    - busy <= 0;
    - rr <= winner+1 mod NUM_REQ;
    - go to IDLE.
- Latency: grant to amci pulse = 1 cycle. Idle-high in WAIT to done = 1 cycle. Back-to-back minimum = 4 cycles per command plus master time.
- rsp_data and rsp_resp hold their value until the next completion.
- Requester rules:
  - req is held until the requester sees done. Addr, wdata and rnw are sampled only at grant.
  - req deasserted before grant: no transaction.
  - req deasserted after grant: the transaction still completes and done still pulses.
  - A requester must drop req on the cycle it sees done, or it is eligible again. Round-robin guarantees the others are served first.
- Simultaneous events:
  - Several req rising in the same cycle: the round-robin order decides.
  - req arriving while busy: waits; it is not queued beyond its level.
- Fairness: with all requesters always requesting, grants cycle 0,1,2,...,NUM_REQ-1,0.
- Reset mid-operation: returns to IDLE immediately. No done is issued. The master's own reset clears its transaction.
- Unknown rnw/addr on non-requesting slots are don't-care.

Decomposition:
- Shared package: state encoding constants (IDLE, ISSUE, SETTLE, WAIT) and AXI response codes (OKAY = 0, SLVERR = 2, DECERR = 3).
- Sub-module rr_pick: combinational round-robin priority selector. Inputs: req vector and rr pointer. Outputs: winner index and a valid flag. It is reused by later arbiters.

Test Plan:
- Single write: req[1]=1, rnw=0, addr=0x4000_0000, wdata=0x5; master widle drops for 5 cycles. Required:
  - amci_write pulses once with waddr=0x4000_0000 and wdata=5;
  - done[1] pulses once with rsp_resp=0 and rsp_data=0.
- Single read: req[2]=1, rnw=1, addr=0x4000_0008; master returns rdata=0xDEAD_BEEF, rresp=0. Required: amci_read pulses once, done[2] pulses, rsp_data=0xDEAD_BEEF.
- Fairness: all four req held high, with each requester re-raising req one cycle after its done. Required: grant order 0,1,2,3,0,1 and no requester served twice in a row.
- Wrap: rr=3 after serving requester 2; req=4'b1001. Required: requester 3 is granted first, then requester 0.
- Error response: a write returns wresp=2. Required: rsp_resp=2 on the done cycle, and the arbiter returns to IDLE and serves the next request.
- Reset mid-WAIT: assert resetn=0 while busy=1. Required:
  - busy, done, amci_write and amci_read are 0 immediately (asynchronous);
  - after release, the next req is granted from rr=0.

Source files
------------

// File: rtl/amci_arbiter_pkg.sv
// Shared definitions for the AMCI arbiter: FSM state encoding, AXI response codes
// and the index-width helper used by the top and the round-robin selector.
package amci_arbiter_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ISSUE  = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;
  localparam logic [1:0] ST_WAIT   = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Width of a requester index; never below one bit so a 2-requester build still works.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/amci_arbiter_rr_pick.sv
// Combinational round-robin selector (rr_pick): returns the first set request bit at
// or above the pointer, wrapping modulo NUM_REQ, plus a flag saying any bit was set.
module amci_arbiter_rr_pick
  import amci_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr,
  output logic [IDX_W-1:0]   winner,
  output logic               valid
);

  logic [IDX_W-1:0] cand;

  // NOTE: every output and temporary gets a default before the loop, so no latch is inferred.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    cand   = '0;
    // Walk from the farthest offset down so the nearest requester to rr is the last write.
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      cand = IDX_W'((int'(rr) + off) % NUM_REQ);
      if (req[cand]) begin
        winner = cand;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/amci_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite master control interface among NUM_REQ
// requesters, with a single transaction outstanding at a time.
module amci_arbiter
  import amci_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_rnw,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [1:0]                rsp_resp,
  output logic                      busy,
  output logic [ADDR_W-1:0]         amci_waddr,
  output logic [DATA_W-1:0]         amci_wdata,
  output logic                      amci_write,
  input  logic [1:0]                amci_wresp,
  input  logic                      amci_widle,
  output logic [ADDR_W-1:0]         amci_raddr,
  output logic                      amci_read,
  input  logic [DATA_W-1:0]         amci_rdata,
  input  logic [1:0]                amci_rresp,
  input  logic                      amci_ridle
);

  localparam int IDX_W = idx_width(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  logic [1:0]        state;
  logic [IDX_W-1:0]  rr;
  logic [IDX_W-1:0]  win_idx;
  logic              win_rnw;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  logic [IDX_W-1:0]  pick_idx;
  logic              pick_valid;
  logic              win_idle;

  amci_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req    (req),
    .rr     (rr),
    .winner (pick_idx),
    .valid  (pick_valid)
  );

  assign win_idle = win_rnw ? amci_ridle : amci_widle;

  // NOTE: sequential state uses non-blocking assignments only; pulse outputs default
  // low at the top of the block and a later assignment in the same cycle overrides it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      rr         <= '0;
      win_idx    <= '0;
      win_rnw    <= 1'b0;
      win_addr   <= '0;
      win_wdata  <= '0;
      done       <= '0;
      rsp_data   <= '0;
      rsp_resp   <= RESP_OKAY;
      busy       <= 1'b0;
      amci_waddr <= '0;
      amci_wdata <= '0;
      amci_write <= 1'b0;
      amci_raddr <= '0;
      amci_read  <= 1'b0;
    end else begin
      done       <= '0;
      amci_write <= 1'b0;
      amci_read  <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (pick_valid && amci_widle && amci_ridle) begin
            win_idx   <= pick_idx;
            win_rnw   <= req_rnw[pick_idx];
            win_addr  <= req_addr[int'(pick_idx) * ADDR_W +: ADDR_W];
            win_wdata <= req_wdata[int'(pick_idx) * DATA_W +: DATA_W];
            busy      <= 1'b1;
            state     <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          if (win_rnw) begin
            amci_raddr <= win_addr;
            amci_read  <= 1'b1;
          end else begin
            amci_waddr <= win_addr;
            amci_wdata <= win_wdata;
            amci_write <= 1'b1;
          end
          state <= ST_SETTLE;
        end

        // The master only drops its idle flag one cycle after the pulse, so skip a cycle.
        ST_SETTLE: state <= ST_WAIT;

        ST_WAIT: begin
          if (win_idle) begin
            rsp_resp      <= win_rnw ? amci_rresp : amci_wresp;
            rsp_data      <= win_rnw ? amci_rdata : '0;
            done[win_idx] <= 1'b1;
            busy          <= 1'b0;
            rr            <= (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
            state         <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
